// File: rtl/hack_pkg.sv
// Shared Hack ALU definitions: word width, word type and the canonical
// control encodings packed as {zx,nx,zy,ny,f,no}.
package hack_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } ctl_t;

  localparam ctl_t CTL_ZERO    = 6'b101010;
  localparam ctl_t CTL_ONE     = 6'b111111;
  localparam ctl_t CTL_NEG1    = 6'b111010;
  localparam ctl_t CTL_X       = 6'b001100;
  localparam ctl_t CTL_Y       = 6'b110000;
  localparam ctl_t CTL_NOT_X   = 6'b001101;
  localparam ctl_t CTL_NOT_Y   = 6'b110001;
  localparam ctl_t CTL_NEG_X   = 6'b001111;
  localparam ctl_t CTL_NEG_Y   = 6'b110011;
  localparam ctl_t CTL_X_INC   = 6'b011111;
  localparam ctl_t CTL_Y_INC   = 6'b110111;
  localparam ctl_t CTL_X_DEC   = 6'b001110;
  localparam ctl_t CTL_Y_DEC   = 6'b110010;
  localparam ctl_t CTL_X_ADD_Y = 6'b000010;
  localparam ctl_t CTL_X_SUB_Y = 6'b010011;
  localparam ctl_t CTL_Y_SUB_X = 6'b000111;
  localparam ctl_t CTL_X_AND_Y = 6'b000000;
  localparam ctl_t CTL_X_OR_Y  = 6'b010101;

endpackage

// File: rtl/hack_alu_core.sv
// Purely combinational Hack ALU datapath: operand conditioning, add/and,
// optional output negation and the zr/ng flags.
module hack_alu_core
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] w_x1;
  logic [WIDTH-1:0] w_x2;
  logic [WIDTH-1:0] w_y1;
  logic [WIDTH-1:0] w_y2;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_out;

  // Zero first, then negate; the adder wraps and drops its carry.
  always_comb begin
    w_x1  = zx ? '0 : x;
    w_x2  = nx ? ~w_x1 : w_x1;
    w_y1  = zy ? '0 : y;
    w_y2  = ny ? ~w_y1 : w_y1;
    w_r   = f ? (w_x2 + w_y2) : (w_x2 & w_y2);
    w_out = no ? ~w_r : w_r;
  end

  assign out = w_out;
  assign zr  = (w_out == '0);
  assign ng  = w_out[WIDTH-1];

endmodule

// File: rtl/hack_alu.sv
// Hack ALU top: combinational result and flags plus an enabled register
// stage for pipelined consumers.
module hack_alu
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic [WIDTH-1:0] out_q,
  output logic             zr_q,
  output logic             ng_q
);

  if (WIDTH < 2) begin : g_width_check
    $error("hack_alu: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] w_out;
  logic             w_zr;
  logic             w_ng;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;

  hack_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .x   (x),
    .y   (y),
    .zx  (zx),
    .nx  (nx),
    .zy  (zy),
    .ny  (ny),
    .f   (f),
    .no  (no),
    .out (w_out),
    .zr  (w_zr),
    .ng  (w_ng)
  );

  // Reset state mirrors a zero result, hence zr_q = 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_zr  <= 1'b1;
      r_ng  <= 1'b0;
    end else if (en) begin
      r_out <= w_out;
      r_zr  <= w_zr;
      r_ng  <= w_ng;
    end
  end

  assign out   = w_out;
  assign zr    = w_zr;
  assign ng    = w_ng;
  assign out_q = r_out;
  assign zr_q  = r_zr;
  assign ng_q  = r_ng;

endmodule

// File: tb/tb_hack_alu.sv
// Scoreboard bench for hack_alu: stimulus queues expected results, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_hack_alu;
  import hack_pkg::*;

  logic  clk = 1'b0;
  logic  rst, zx, nx, zy, ny, f, no, en;
  word_t x, y, out, out_q;
  logic  zr, ng, zr_q, ng_q;

  always #5 clk = ~clk;

  hack_alu #(.WIDTH(WORD_W)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .en(en),
    .out(out), .zr(zr), .ng(ng),
    .out_q(out_q), .zr_q(zr_q), .ng_q(ng_q)
  );

  typedef struct {
    bit    is_reg;
    string name;
    word_t o;
    logic  z;
    logic  n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(bit r, string nm, word_t o);
    exp_t e;
    e.is_reg = r;
    e.name   = nm;
    e.o      = o;
    e.z      = (o == '0);
    e.n      = o[WORD_W-1];
    return e;
  endfunction

  function automatic word_t ref_alu(ctl_t c, word_t a, word_t b);
    word_t xa, yb, r;
    xa = c.zx ? 16'h0000 : a;
    if (c.nx) xa = ~xa;
    yb = c.zy ? 16'h0000 : b;
    if (c.ny) yb = ~yb;
    r = c.f ? 16'(xa + yb) : (xa & yb);
    return c.no ? ~r : r;
  endfunction

  task automatic push_comb(string nm, word_t o);
    sb.push_back(mk(1'b0, nm, o));
  endtask

  task automatic push_reg(string nm, word_t o);
    sb.push_back(mk(1'b1, nm, o));
  endtask

  task automatic drive(ctl_t c, word_t xv, word_t yv, logic env, logic rstv);
    @(posedge clk);
    #1;
    {zx, nx, zy, ny, f, no} = c;
    x   = xv;
    y   = yv;
    en  = env;
    rst = rstv;
  endtask

  task automatic vec(string nm, ctl_t c, word_t xv, word_t yv, word_t o);
    drive(c, xv, yv, 1'b0, 1'b0);
    push_comb(nm, o);
  endtask

  // Monitor: every queued expectation is checked on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (e.is_reg) begin
          if (out_q !== e.o || zr_q !== e.z || ng_q !== e.n) begin
            n_fail++;
            $display("FAIL %s (registered): got out_q=%h zr_q=%b ng_q=%b, expected out_q=%h zr_q=%b ng_q=%b",
                     e.name, out_q, zr_q, ng_q, e.o, e.z, e.n);
          end
        end else begin
          if (out !== e.o || zr !== e.z || ng !== e.n) begin
            n_fail++;
            $display("FAIL %s (comb): got out=%h zr=%b ng=%b, expected out=%h zr=%b ng=%b",
                     e.name, out, zr, ng, e.o, e.z, e.n);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctl_t  enc [18];
    ctl_t  c;
    word_t xv, yv, ev, prev;

    enc = '{CTL_ZERO, CTL_ONE, CTL_NEG1, CTL_X, CTL_Y, CTL_NOT_X, CTL_NOT_Y,
            CTL_NEG_X, CTL_NEG_Y, CTL_X_INC, CTL_Y_INC, CTL_X_DEC, CTL_Y_DEC,
            CTL_X_ADD_Y, CTL_X_SUB_Y, CTL_Y_SUB_X, CTL_X_AND_Y, CTL_X_OR_Y};

    rst = 1'b1; en = 1'b0;
    {zx, nx, zy, ny, f, no} = 6'b000000;
    x = '0; y = '0;

    // Reset beats enable; combinational path keeps tracking.
    drive(CTL_X, 16'h1234, 16'h0000, 1'b1, 1'b1);
    push_comb("rst_comb_track", 16'h1234);

    drive(CTL_ZERO, 16'h1234, 16'hFFFE, 1'b0, 1'b0);
    push_reg("reset_state", 16'h0000);
    push_comb("const_0", 16'h0000);
    vec("const_1",  CTL_ONE,  16'h1234, 16'hFFFE, 16'h0001);
    vec("const_m1", CTL_NEG1, 16'h1234, 16'hFFFE, 16'hFFFF);

    vec("pass_x",  CTL_X,     16'h1234, 16'hFFFE, 16'h1234);
    vec("not_y",   CTL_NOT_Y, 16'h1234, 16'hFFFE, 16'h0001);
    vec("neg_x",   CTL_NEG_X, 16'h1234, 16'hFFFE, 16'hEDCC);
    vec("x_inc",   CTL_X_INC, 16'h1234, 16'hFFFE, 16'h1235);
    vec("y_dec",   CTL_Y_DEC, 16'h1234, 16'hFFFE, 16'hFFFD);

    vec("x_add_y", CTL_X_ADD_Y, 16'h00F0, 16'h0F0F, 16'h0FFF);
    vec("x_sub_y", CTL_X_SUB_Y, 16'h00F0, 16'h0F0F, 16'hF1E1);
    vec("y_sub_x", CTL_Y_SUB_X, 16'h00F0, 16'h0F0F, 16'h0E1F);
    vec("x_and_y", CTL_X_AND_Y, 16'h00F0, 16'h0F0F, 16'h0000);
    vec("x_or_y",  CTL_X_OR_Y,  16'h00F0, 16'h0F0F, 16'h0FFF);

    vec("wrap_pos", CTL_X_INC, 16'h7FFF, 16'h0000, 16'h8000);
    vec("wrap_zero", CTL_X_INC, 16'hFFFF, 16'h0000, 16'h0000);
    push_reg("hold_reset_en0", 16'h0000);

    // Capture with en, then hold while inputs move.
    drive(CTL_X_ADD_Y, 16'h0005, 16'hFFF9, 1'b1, 1'b0);
    push_comb("cap_comb", 16'hFFFE);
    drive(CTL_X_ADD_Y, 16'h0001, 16'h0001, 1'b0, 1'b0);
    push_reg("cap_reg", 16'hFFFE);
    push_comb("hold_comb", 16'h0002);
    drive(CTL_X_ADD_Y, 16'h0001, 16'h0001, 1'b0, 1'b0);
    push_reg("hold_reg", 16'hFFFE);

    // Mid-operation reset clears only the register stage.
    drive(CTL_X, 16'h00AA, 16'h0000, 1'b1, 1'b1);
    push_comb("midrst_comb", 16'h00AA);
    drive(CTL_X, 16'h00AA, 16'h0000, 1'b1, 1'b0);
    push_reg("midrst_reg", 16'h0000);
    drive(CTL_Y, 16'h00AA, 16'h0055, 1'b0, 1'b0);
    push_reg("after_rst_cap", 16'h00AA);
    push_comb("after_rst_comb", 16'h0055);

    prev = '0;
    for (int i = 0; i < 1000; i++) begin
      c  = enc[$urandom_range(0, 17)];
      xv = 16'($urandom);
      yv = 16'($urandom);
      drive(c, xv, yv, 1'b1, 1'b0);
      if (i > 0) push_reg("rnd_reg", prev);
      ev = ref_alu(c, xv, yv);
      push_comb("rnd_comb", ev);
      prev = ev;
    end
    drive(CTL_ZERO, 16'h0000, 16'h0000, 1'b0, 1'b0);
    push_reg("rnd_reg_last", prev);

    @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
